// File: rtl/haz_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package haz_pkg;

  // Ready-stage codes as carried by decode.
  localparam int unsigned RDY_ALU  = 1;
  localparam int unsigned RDY_LOAD = 2;

  // Stored ready stage is already clamped to 1..NSTAGE, and NSTAGE <= 6 fits in 3 bits.
  localparam int unsigned RDY_ENT_W = 3;

  // One shadow-pipe entry: destination tag of the instruction in that stage.
  typedef struct packed {
    logic                 vld;
    logic [4:0]           rd;
    logic                 we;
    logic [RDY_ENT_W-1:0] rdy;
  } haz_entry_t;

  // Width of a forwarding select: 0 = regfile, 1..nstage = stage result.
  function automatic int unsigned fsel_w(input int unsigned nstage);
    return $clog2(nstage + 1);
  endfunction

  // 0 behaves like an ALU result; anything past the last stage only appears at WB.
  function automatic logic [RDY_ENT_W-1:0] clamp_rdy(input int unsigned rdy,
                                                     input int unsigned nstage);
    int unsigned r;
    r = rdy;
    if (r == 0) begin
      r = RDY_ALU;
    end else if (r > nstage) begin
      r = nstage;
    end
    return r[RDY_ENT_W-1:0];
  endfunction

endpackage

// File: rtl/haz_src_match.sv
// Compares one source operand against every shadow-pipe entry and picks the youngest producer.
module haz_src_match
  import haz_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned NREG   = 32,
  parameter int unsigned FSEL_W = 2
) (
  input  haz_entry_t [NSTAGE-1:0] ents_i,
  input  logic [4:0]              rs_i,
  input  logic                    rs_en_i,
  output logic [FSEL_W-1:0]       fwd_sel_o,
  output logic                    hazard_o
);

  // Walk oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    fwd_sel_o = '0;
    hazard_o  = 1'b0;
    for (int unsigned k = NSTAGE; k >= 1; k--) begin
      if (ents_i[k-1].vld && ents_i[k-1].we && (ents_i[k-1].rd != 5'd0) &&
          (32'(ents_i[k-1].rd) < NREG) && (ents_i[k-1].rd == rs_i) && rs_en_i) begin
        if (k >= 32'(ents_i[k-1].rdy)) begin
          fwd_sel_o = FSEL_W'(k);
          hazard_o  = 1'b0;
        end else begin
          fwd_sel_o = '0;
          hazard_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shadow pipe of destination tags after ID, per-operand
// forwarding selects, stall/bubble control, memory-wait freeze and retire reporting.
// Optional HAZ_PERF_CNT_EN adds stall-cycle and retire counters.
module pipe_hazard_ctrl
  import haz_pkg::*;
#(
  parameter  int unsigned NSTAGE = 3,
  parameter  int unsigned NREG   = 32,
  parameter  int unsigned RDY_W  = 3,
  localparam int unsigned FSEL_W = fsel_w(NSTAGE)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [4:0]        dec_rs1,
  input  logic              dec_rs1_en,
  input  logic [4:0]        dec_rs2,
  input  logic              dec_rs2_en,
  input  logic [4:0]        dec_rd,
  input  logic              dec_rd_we,
  input  logic [RDY_W-1:0]  dec_rdy_stg,
  input  logic              flush,
  input  logic              mem_wait,
  output logic [FSEL_W-1:0] rs1_fwd_sel,
  output logic [FSEL_W-1:0] rs2_fwd_sel,
  output logic              stall,
  output logic              ret_valid,
  output logic [4:0]        ret_rd,
  output logic              ret_we
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_ret_cnt
`endif
);

  haz_entry_t [NSTAGE-1:0] stage_q;
  haz_entry_t              dec_ent;
  haz_entry_t              last_ent;
  logic [FSEL_W-1:0]       sel1, sel2;
  logic                    haz1, haz2;
  logic                    hazard;

  haz_src_match #(
    .NSTAGE (NSTAGE),
    .NREG   (NREG),
    .FSEL_W (FSEL_W)
  ) u_match_rs1 (
    .ents_i    (stage_q),
    .rs_i      (dec_rs1),
    .rs_en_i   (dec_rs1_en),
    .fwd_sel_o (sel1),
    .hazard_o  (haz1)
  );

  haz_src_match #(
    .NSTAGE (NSTAGE),
    .NREG   (NREG),
    .FSEL_W (FSEL_W)
  ) u_match_rs2 (
    .ents_i    (stage_q),
    .rs_i      (dec_rs2),
    .rs_en_i   (dec_rs2_en),
    .fwd_sel_o (sel2),
    .hazard_o  (haz2)
  );

  // Entry that ID would push into stage 1, with the ready stage clamped to 1..NSTAGE.
  always_comb begin
    dec_ent     = '0;
    dec_ent.vld = dec_valid;
    dec_ent.rd  = dec_rd;
    dec_ent.we  = dec_rd_we;
    dec_ent.rdy = clamp_rdy(32'(dec_rdy_stg), NSTAGE);
  end

  assign hazard = dec_valid & (haz1 | haz2);

  // Shadow pipe: each stage holds on mem_wait, otherwise takes its younger neighbour.
  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    haz_entry_t ent_in;
    haz_entry_t ent_d;

    if (g == 0) begin : g_first
      // Flush or an unresolved hazard inserts a bubble; ID is re-evaluated next cycle.
      assign ent_in = (flush || hazard) ? '0 : dec_ent;
    end else begin : g_rest
      assign ent_in = stage_q[g-1];
    end

    assign ent_d = mem_wait ? stage_q[g] : ent_in;

    // Stage register with synchronous clear.
    always_ff @(posedge clock) begin
      if (rst) begin
        stage_q[g] <= '0;
      end else begin
        stage_q[g] <= ent_d;
      end
    end
  end

  assign last_ent = stage_q[NSTAGE-1];

  // Outputs are forced quiet while reset is held.
  always_comb begin
    rs1_fwd_sel = rst ? '0 : sel1;
    rs2_fwd_sel = rst ? '0 : sel2;
    stall       = ~rst & (mem_wait | (dec_valid & ~flush & (haz1 | haz2)));
    ret_valid   = ~rst & ~mem_wait & last_ent.vld;
    ret_rd      = ret_valid ? last_ent.rd : 5'd0;
    ret_we      = ret_valid & last_ent.we;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, ret_cnt_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (rst) begin
      stall_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ret_valid) ret_cnt_q <= ret_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_ret_cnt   = ret_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (NSTAGE=3): forwarding, load-use, x0, mem_wait,
// flush, reset-mid-stall, ready-stage clamping and same-rd priority.
module tb_pipe_hazard_ctrl;

  logic       clock;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic       dec_rs1_en;
  logic [4:0] dec_rs2;
  logic       dec_rs2_en;
  logic [4:0] dec_rd;
  logic       dec_rd_we;
  logic [2:0] dec_rdy_stg;
  logic       flush;
  logic       mem_wait;
  logic [1:0] rs1_fwd_sel;
  logic [1:0] rs2_fwd_sel;
  logic       stall;
  logic       ret_valid;
  logic [4:0] ret_rd;
  logic       ret_we;

  int n_checks = 0;
  int n_err    = 0;

  pipe_hazard_ctrl #(
    .NSTAGE (3),
    .NREG   (32),
    .RDY_W  (3)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .dec_valid   (dec_valid),
    .dec_rs1     (dec_rs1),
    .dec_rs1_en  (dec_rs1_en),
    .dec_rs2     (dec_rs2),
    .dec_rs2_en  (dec_rs2_en),
    .dec_rd      (dec_rd),
    .dec_rd_we   (dec_rd_we),
    .dec_rdy_stg (dec_rdy_stg),
    .flush       (flush),
    .mem_wait    (mem_wait),
    .rs1_fwd_sel (rs1_fwd_sel),
    .rs2_fwd_sel (rs2_fwd_sel),
    .stall       (stall),
    .ret_valid   (ret_valid),
    .ret_rd      (ret_rd),
    .ret_we      (ret_we)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the ID slot, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic e1,
                       input logic [4:0] rs2, input logic e2, input logic [4:0] rd,
                       input logic we, input logic [2:0] rdy);
    dec_valid   = v;
    dec_rs1     = rs1;
    dec_rs1_en  = e1;
    dec_rs2     = rs2;
    dec_rs2_en  = e2;
    dec_rd      = rd;
    dec_rd_we   = we;
    dec_rdy_stg = rdy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    mem_wait = 1'b0;
    idle();
    repeat (2) tick();
    chk("rst_fwd1", 32'(rs1_fwd_sel), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ret", 32'(ret_valid), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ret", 32'(ret_valid), 0);
    chk("post_rst_stall", 32'(stall), 0);

    // addi x5 ; add x6,x5,x5
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1);
    chk("alu_first_stall", 32'(stall), 0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 3'd1);
    chk("alu_fwd1", 32'(rs1_fwd_sel), 1);
    chk("alu_fwd2", 32'(rs2_fwd_sel), 1);
    chk("alu_stall", 32'(stall), 0);
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 3'd1);
    chk("rs2_disabled", 32'(rs2_fwd_sel), 0);
    tick();
    idle();
    tick();
    chk("ret_addi_v", 32'(ret_valid), 1);
    chk("ret_addi_rd", 32'(ret_rd), 5);
    chk("ret_addi_we", 32'(ret_we), 1);
    tick();
    chk("ret_add_rd", 32'(ret_rd), 6);
    tick();
    chk("ret_empty", 32'(ret_valid), 0);
    drain();

    // lw x5 ; add x6,x5,x0 : one stall cycle, then forward from stage 2
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 3'd1);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_fwd1_hz", 32'(rs1_fwd_sel), 0);
    tick();
    chk("lu_stall_after", 32'(stall), 0);
    chk("lu_fwd1", 32'(rs1_fwd_sel), 2);
    chk("lu_fwd2_x0", 32'(rs2_fwd_sel), 0);
    tick();
    idle();
    chk("lu_ret_lw", 32'(ret_rd), 5);
    tick();
    chk("lu_bubble", 32'(ret_valid), 0);
    tick();
    chk("lu_ret_add", 32'(ret_rd), 6);
    drain();

    // lw x5 ; nop ; consumers two/three/four apart (consumers write nothing)
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
    chk("apart2_fwd", 32'(rs1_fwd_sel), 2);
    chk("apart2_stall", 32'(stall), 0);
    tick();
    chk("apart3_fwd", 32'(rs1_fwd_sel), 3);
    chk("apart3_ret", 32'(ret_rd), 5);
    tick();
    chk("apart4_fwd", 32'(rs1_fwd_sel), 0);
    drain();

    // addi x0 ; add x6,x0,x0
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd1);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 3'd1);
    chk("x0_fwd1", 32'(rs1_fwd_sel), 0);
    chk("x0_fwd2", 32'(rs2_fwd_sel), 0);
    chk("x0_stall", 32'(stall), 0);
    drain();

    // mem_wait for 3 cycles with lw in MEM
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
    tick();
    idle();
    tick();
    mem_wait = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mw_stall", 32'(stall), 1);
      chk("mw_ret", 32'(ret_valid), 0);
      chk("mw_fwd_frozen", 32'(rs1_fwd_sel), 2);
      tick();
    end
    mem_wait = 1'b0;
    #1;
    chk("mw_release_stall", 32'(stall), 0);
    chk("mw_release_fwd", 32'(rs1_fwd_sel), 2);
    tick();
    idle();
    chk("mw_ret_lw_v", 32'(ret_valid), 1);
    chk("mw_ret_lw_rd", 32'(ret_rd), 5);
    drain();

    // flush with a hazardous ID instruction
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
    tick();
    flush = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd1);
    chk("flush_stall", 32'(stall), 0);
    tick();
    flush = 1'b0;
    idle();
    tick();
    chk("flush_ret_lw", 32'(ret_rd), 5);
    tick();
    chk("flush_bubble", 32'(ret_valid), 0);
    drain();

    // reset asserted mid-stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd1);
    chk("rms_stall", 32'(stall), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rms_stall_clr", 32'(stall), 0);
    chk("rms_fwd1", 32'(rs1_fwd_sel), 0);
    chk("rms_ret", 32'(ret_valid), 0);
    drain();

    // ready-stage clamps: 0 acts as 1, 5 acts as 3
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
    chk("rdy0_fwd", 32'(rs1_fwd_sel), 1);
    chk("rdy0_stall", 32'(stall), 0);
    drain();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd5);
    tick();
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
    chk("rdy5_stall_s1", 32'(stall), 1);
    tick();
    chk("rdy5_stall_s2", 32'(stall), 1);
    tick();
    chk("rdy5_fwd3", 32'(rs1_fwd_sel), 3);
    chk("rdy5_nostall", 32'(stall), 0);
    drain();

    // same rd in two stages: youngest decides
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd2);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd1);
    tick();
    drive(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
    chk("dup_young_alu", 32'(rs1_fwd_sel), 1);
    drain();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd1);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd2);
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
    chk("dup_young_load_stall", 32'(stall), 1);
    chk("dup_young_load_fwd", 32'(rs1_fwd_sel), 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
